mc8051_mem_arbiter: RTL and testbench
=====================================

// Module: mc8051_mem_arbiter
// PURPOSE
//  Shares the single naive-memory interface (mem_* bus) between the core BIU (port 0) and a DMA/debug master (port 1).
//  Fixed CPU priority with a DMA anti-starvation counter; one transaction owns the bus until mem_data_rdy.
//  A watchdog terminates transfers whose mem_data_rdy never arrives. Sits between biu and the memory/SFR fabric.
// PARAMETERS
//  CPU_BURST_MAX  4    consecutive CPU grants allowed while dma_req pending; then 1 DMA grant is forced (>=1)
//  TIMEOUT_CYC    255  max cycles in XFER waiting for mem_data_rdy; 0 disables the watchdog
// PORTS
//  clk             in   1   single clock; all state on posedge
//  reset_n         in   1   synchronous active-low reset
//  cpu_we_n/cpu_rd_n/cpu_psen_n/cpu_sfr_n  in 1 each  BIU strobes; request = any of we/rd/psen low
//  cpu_addr        in   16  CPU address;  cpu_wdata in 8  CPU write data
//  cpu_data_rdy    out  1   1-cycle completion pulse to BIU;  cpu_rdata out 8  read data (valid with pulse)
//  cpu_err         out  1   1-cycle pulse with cpu_data_rdy when completed by timeout
//  dma_req         in   1   level request, held until dma_ack;  dma_we in 1  1=write 0=read (XDATA only)
//  dma_addr        in   16  DMA address;  dma_wdata in 8  DMA write data
//  dma_ack         out  1   1-cycle completion pulse;  dma_rdata out 8;  dma_err out 1 (timeout, with ack)
//  mem_we_n/mem_rd_n/mem_psen_n/mem_sfr_n  out 1 each  downstream strobes (registered)
//  mem_addr        out  16  registered;  mem_wdata out 8  registered
//  mem_data_rdy    in   1   downstream completion;  mem_rdata in 8  downstream read data
//  bus_owner       out  1   0=CPU 1=DMA, valid while mem strobes active
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): strobes=1, mem_addr=0, mem_wdata=0, all rdy/ack/err=0, rdata=0, bus_owner=0,
//   state=IDLE, burst/timeout counters=0. Reset mid-transfer aborts it; no completion pulse is issued.
//  FSM IDLE -> CPU_XFER | DMA_XFER -> IDLE. Exactly one outstanding transfer.
//  IDLE: force_dma = dma_req && burst_cnt==CPU_BURST_MAX. If cpu_req && !force_dma -> CPU_XFER, latch cpu strobes/
//   addr/wdata, burst_cnt += (dma_req?1:0). Else if dma_req -> DMA_XFER, latch dma fields, burst_cnt=0,
//   mem_we_n=~dma_we, mem_rd_n=dma_we, mem_psen_n=1, mem_sfr_n=1. burst_cnt=0 whenever dma_req=0.
//  Latency: request sampled in IDLE cycle N -> mem strobes low from N+1. mem_data_rdy=1 sampled at cycle M ->
//   owner pulse + rdata registered at M+1, strobes high at M+1, state IDLE at M+1, next grant earliest M+2.
//  mem_data_rdy sampled in IDLE is ignored. CPU strobes are forwarded as latched (multiple lows passed unchanged).
//  Requesters must hold request and fields stable until their pulse; changes mid-transfer are not seen.
//  CPU in IDLE not granted (DMA won): cpu_data_rdy stays 0 (BIU stalls); CPU served next IDLE.
//  Watchdog: tmo_cnt clears on grant, +1 per XFER cycle without rdy; at tmo_cnt==TIMEOUT_CYC-1 and no rdy ->
//   complete as normal with rdata=8'hFF and err=1. rdy on the same cycle as expiry wins (err=0).
//  Simultaneous cpu_req & dma_req in IDLE with burst_cnt<CPU_BURST_MAX -> CPU; at ==CPU_BURST_MAX -> DMA.
//  Writes: owner rdata output = 8'h00 on completion pulse.
// STRUCTURE
//  global_param.v: ARB_IDLE/ARB_CPU/ARB_DMA encodings, ARB_TMO_RDATA=8'hFF.
//  Sub-module mc8051_bus_watchdog (clear, enable, expire; width $clog2(TIMEOUT_CYC+1)); rest flat.
// TESTING
//  1 CPU rd_n=0 addr 16'h1234, mem_rdata 8'hA5 rdy 2 cycles later -> mem_rd_n low N+1, cpu_rdata=A5 + 1 pulse.
//  2 DMA write addr 16'h8000 data 8'h3C alone -> mem_we_n=0, psen/sfr=1, dma_ack pulse, cpu_data_rdy stays 0.
//  3 CPU continuous + dma_req held, CPU_BURST_MAX=4 -> grants CPU x4, DMA x1, CPU x4; DMA never starved.
//  4 CPU psen_n=0, mem_data_rdy never rises, TIMEOUT_CYC=8 -> cpu_err+cpu_data_rdy at 8th XFER cycle+1, rdata FF.
//  5 reset_n=0 during DMA_XFER -> next cycle strobes high, no dma_ack; after reset new CPU req served normally.
//  6 rdy coincident with watchdog expiry -> normal completion, err=0; mem_data_rdy in IDLE -> no pulse.

Source files
------------

// File: rtl/mc8051_mem_arbiter_pkg.sv
// Shared types and constants for the mc8051 memory arbiter.
// Arbiter state encodings, downstream request bundle, completion data select.
package mc8051_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_e;

    localparam logic [7:0] ARB_TMO_RDATA = 8'hFF;
    localparam logic [7:0] ARB_WR_RDATA  = 8'h00;

    typedef struct packed {
        logic        we_n;
        logic        rd_n;
        logic        psen_n;
        logic        sfr_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '{
        we_n:   1'b1,
        rd_n:   1'b1,
        psen_n: 1'b1,
        sfr_n:  1'b1,
        addr:   16'h0000,
        wdata:  8'h00
    };

    // A timed-out transfer reports FF even for writes.
    function automatic logic [7:0] done_rdata(
        input logic       tmo,
        input logic       wr,
        input logic [7:0] rd
    );
        logic [7:0] v;
        v = rd;
        if (tmo) begin
            v = ARB_TMO_RDATA;
        end else if (wr) begin
            v = ARB_WR_RDATA;
        end
        return v;
    endfunction

endpackage

// File: rtl/mc8051_bus_watchdog.sv
// Transfer watchdog: counts stalled cycles, flags the last allowed one.
// TIMEOUT_CYC of 0 never expires.
module mc8051_bus_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT_CYC != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mc8051_mem_arbiter.sv
// Two-master arbiter for the naive memory bus: BIU has priority,
// DMA gets a forced slot after CPU_BURST_MAX back-to-back CPU grants.
module mc8051_mem_arbiter
    import mc8051_mem_arbiter_pkg::*;
#(
    parameter int CPU_BURST_MAX = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_we_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_psen_n,
    input  logic        cpu_sfr_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_data_rdy,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_err,
    output logic        mem_we_n,
    output logic        mem_rd_n,
    output logic        mem_psen_n,
    output logic        mem_sfr_n,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_data_rdy,
    input  logic [7:0]  mem_rdata,
    output logic        bus_owner
);

    localparam int BW = $clog2(CPU_BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(CPU_BURST_MAX);

    arb_state_e    state_q, state_d;
    mem_req_t      req_q, req_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          owner_q, owner_d;
    logic          cpu_rdy_q, cpu_rdy_d;
    logic          cpu_err_q, cpu_err_d;
    logic          dma_ack_q, dma_ack_d;
    logic          dma_err_q, dma_err_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    dma_rdata_q, dma_rdata_d;

    logic       cpu_req;
    logic       idle;
    logic       in_xfer;
    logic       force_dma;
    logic       grant_cpu;
    logic       grant_dma;
    logic       expire;
    logic       done;
    logic [7:0] fin_rdata;

    assign cpu_req   = ~(cpu_we_n & cpu_rd_n & cpu_psen_n);
    assign idle      = (state_q == ARB_IDLE);
    assign in_xfer   = ~idle;
    assign force_dma = dma_req && (burst_q == BURST_LIM);
    assign grant_cpu = idle && cpu_req && !force_dma;
    assign grant_dma = idle && !grant_cpu && dma_req;
    assign done      = in_xfer && (mem_data_rdy || expire);
    assign fin_rdata = done_rdata(expire, ~req_q.we_n, mem_rdata);

    mc8051_bus_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (idle),
        .enable_i (in_xfer && !mem_data_rdy),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_cpu) begin
                    state_d = ARB_CPU;
                end else if (grant_dma) begin
                    state_d = ARB_DMA;
                end
            end
            ARB_CPU, ARB_DMA: begin
                if (done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_d       = req_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        cpu_rdy_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (1'b1)
            grant_cpu: begin
                req_d = '{
                    we_n:   cpu_we_n,
                    rd_n:   cpu_rd_n,
                    psen_n: cpu_psen_n,
                    sfr_n:  cpu_sfr_n,
                    addr:   cpu_addr,
                    wdata:  cpu_wdata
                };
                owner_d = 1'b0;
                burst_d = burst_q + BW'(dma_req);
            end
            grant_dma: begin
                req_d = '{
                    we_n:   ~dma_we,
                    rd_n:   dma_we,
                    psen_n: 1'b1,
                    sfr_n:  1'b1,
                    addr:   dma_addr,
                    wdata:  dma_wdata
                };
                owner_d = 1'b1;
                burst_d = '0;
            end
            done: begin
                req_d.we_n   = 1'b1;
                req_d.rd_n   = 1'b1;
                req_d.psen_n = 1'b1;
                req_d.sfr_n  = 1'b1;
                if (owner_q) begin
                    dma_ack_d   = 1'b1;
                    dma_err_d   = expire;
                    dma_rdata_d = fin_rdata;
                end else begin
                    cpu_rdy_d   = 1'b1;
                    cpu_err_d   = expire;
                    cpu_rdata_d = fin_rdata;
                end
            end
            default: ;
        endcase
        // The starvation count only matters while DMA is actually waiting.
        if (!dma_req) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q       <= MEM_REQ_IDLE;
            owner_q     <= 1'b0;
            burst_q     <= '0;
            cpu_rdy_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            req_q       <= req_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            cpu_rdy_q   <= cpu_rdy_d;
            cpu_err_q   <= cpu_err_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_we_n     = req_q.we_n;
    assign mem_rd_n     = req_q.rd_n;
    assign mem_psen_n   = req_q.psen_n;
    assign mem_sfr_n    = req_q.sfr_n;
    assign mem_addr     = req_q.addr;
    assign mem_wdata    = req_q.wdata;
    assign bus_owner    = owner_q;
    assign cpu_data_rdy = cpu_rdy_q;
    assign cpu_err      = cpu_err_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dma_ack      = dma_ack_q;
    assign dma_err      = dma_err_q;
    assign dma_rdata    = dma_rdata_q;

endmodule

// File: tb/tb_mc8051_mem_arbiter.sv
// Scoreboard bench for mc8051_mem_arbiter: random two-master traffic,
// a memory responder with chosen latencies, timeouts and a reset abort.
module tb_mc8051_mem_arbiter;

    localparam int BURST = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_we_n, cpu_rd_n, cpu_psen_n, cpu_sfr_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_data_rdy, cpu_err;
    logic [7:0]  cpu_rdata;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack, dma_err;
    logic [7:0]  dma_rdata;
    logic        mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_data_rdy = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        bus_owner;

    mc8051_mem_arbiter #(
        .CPU_BURST_MAX(BURST),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_we_n(cpu_we_n), .cpu_rd_n(cpu_rd_n),
        .cpu_psen_n(cpu_psen_n), .cpu_sfr_n(cpu_sfr_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_data_rdy(cpu_data_rdy), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_we_n(mem_we_n), .mem_rd_n(mem_rd_n),
        .mem_psen_n(mem_psen_n), .mem_sfr_n(mem_sfr_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_rdy(mem_data_rdy), .mem_rdata(mem_rdata),
        .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  strb;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        owner;
        int          lat;
        logic [7:0]  rd;
    } bus_t;

    typedef struct {
        logic       owner;
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    cpu_pend = 0;
    bit    dma_pend = 0;
    int    streak = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Memory responder: checks each new bus request, answers after cur.lat cycles.
    bus_t cur;
    int   k = 0;
    bit   seen = 0;
    always @(negedge clk) begin
        if (!(mem_we_n && mem_rd_n && mem_psen_n)) begin
            if (!seen) begin
                seen = 1;
                k = 1;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur.lat = 0;
                    $display("FAIL bus_unexpected: transfer at addr %0h, required none",
                             mem_addr);
                end else begin
                    cur = bus_q.pop_front();
                    chk("mem_strobes",
                        {mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n}, cur.strb);
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_wdata", mem_wdata, cur.wdata);
                    chk("bus_owner", bus_owner, cur.owner);
                end
            end else begin
                k++;
            end
            mem_data_rdy = (cur.lat != 0) && (k == cur.lat);
            mem_rdata = mem_data_rdy ? cur.rd : 8'($urandom);
        end else begin
            seen = 0;
            mem_data_rdy = ($urandom_range(3) == 0);
            mem_rdata = 8'($urandom);
        end
    end

    // Completion monitor.
    resp_t mr;
    always @(negedge clk) begin
        if (cpu_data_rdy || dma_ack) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: cpu_data_rdy=%0b dma_ack=%0b, required none",
                         cpu_data_rdy, dma_ack);
            end else begin
                mr = resp_q.pop_front();
                chk("pulse_owner", {cpu_data_rdy, dma_ack},
                    mr.owner ? 2'b01 : 2'b10);
                chk("rdata", mr.owner ? dma_rdata : cpu_rdata, mr.rdata);
                chk("err", mr.owner ? dma_err : cpu_err, mr.err);
            end
        end
        if ((cpu_err && !cpu_data_rdy) || (dma_err && !dma_ack)) begin
            checks++;
            errors++;
            $display("FAIL stray_err: cpu_err=%0b dma_err=%0b without pulse",
                     cpu_err, dma_err);
        end
    end

    task automatic issue_cpu(input logic [2:0] lows_n, input logic sfr,
                             input logic [15:0] a, input logic [7:0] d);
        cpu_we_n   = lows_n[2];
        cpu_rd_n   = lows_n[1];
        cpu_psen_n = lows_n[0];
        cpu_sfr_n  = sfr;
        cpu_addr   = a;
        cpu_wdata  = d;
        cpu_pend   = 1;
    endtask

    task automatic issue_dma(input logic we, input logic [15:0] a,
                             input logic [7:0] d);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = a;
        dma_wdata = d;
        dma_pend  = 1;
    endtask

    task automatic cpu_idle();
        cpu_we_n = 1'b1; cpu_rd_n = 1'b1;
        cpu_psen_n = 1'b1; cpu_sfr_n = 1'b1;
        cpu_pend = 0;
    endtask

    task automatic dma_idle();
        dma_req = 1'b0;
        dma_pend = 0;
    endtask

    task automatic rand_cpu();
        issue_cpu(3'($urandom_range(6)), 1'($urandom),
                  16'($urandom), 8'($urandom));
    endtask

    task automatic rand_dma();
        issue_dma(1'($urandom), 16'($urandom), 8'($urandom));
    endtask

    function automatic int pick_lat();
        return ($urandom_range(9) == 0) ? 0 : int'($urandom_range(TMO, 1));
    endfunction

    // Predict the winner from pending requests, queue expectations, await the pulse.
    // lat = cycle of rdy within the transfer (1-based); 0 = never answer.
    task automatic serve(input int lat, input logic [7:0] rd);
        bus_t  b;
        resp_t r;
        logic  win, wr;
        bit    got;
        if (!cpu_pend && !dma_pend) return;
        win = !(cpu_pend && !(dma_pend && streak == BURST));
        if (!win) begin
            streak  = dma_pend ? streak + 1 : 0;
            b.strb  = {cpu_we_n, cpu_rd_n, cpu_psen_n, cpu_sfr_n};
            b.addr  = cpu_addr;
            b.wdata = cpu_wdata;
            wr      = !cpu_we_n;
        end else begin
            streak  = 0;
            b.strb  = {!dma_we, dma_we, 2'b11};
            b.addr  = dma_addr;
            b.wdata = dma_wdata;
            wr      = dma_we;
        end
        b.owner = win;
        b.lat   = lat;
        b.rd    = rd;
        r.owner = win;
        r.err   = (lat == 0);
        r.rdata = (lat == 0) ? 8'hFF : (wr ? 8'h00 : rd);
        bus_q.push_back(b);
        resp_q.push_back(r);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0)
                chk("grant_latency",
                    32'({mem_we_n, mem_rd_n, mem_psen_n} != 3'b111), 1);
            if (cpu_data_rdy || dma_ack) begin
                got = 1;
                chk("pulse_cycle", i, (lat == 0) ? TMO : lat);
                chk("strobe_release",
                    {mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n}, 4'hF);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout: no completion in 40 cycles, required one");
        end
        if (win) dma_idle();
        else cpu_idle();
    endtask

    task automatic rand_round(input int p_cpu, input int p_dma);
        if (!cpu_pend && $urandom_range(99) < p_cpu) rand_cpu();
        if (!dma_pend && $urandom_range(99) < p_dma) rand_dma();
        if (!cpu_pend && !dma_pend) begin
            repeat ($urandom_range(3, 1)) @(negedge clk);
            if ($urandom_range(1) == 1) rand_cpu();
            else rand_dma();
        end
        serve(pick_lat(), 8'($urandom));
    endtask

    task automatic abort_test();
        bus_t b;
        issue_dma(1'b0, 16'hC0DE, 8'h00);
        b.strb = 4'b1011; b.addr = 16'hC0DE; b.wdata = 8'h00;
        b.owner = 1'b1; b.lat = 0; b.rd = 8'h00;
        bus_q.push_back(b);
        repeat (3) @(negedge clk);
        chk("abort_active", mem_rd_n, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        dma_idle();
        streak = 0;
        chk("abort_strobes", {mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n}, 4'hF);
        chk("abort_owner", bus_owner, 0);
        chk("abort_no_ack", {dma_ack, dma_err}, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        cpu_addr = 16'h0; cpu_wdata = 8'h0;
        dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;
        cpu_idle();
        dma_idle();
        repeat (3) @(negedge clk);
        chk("reset_strobes", {mem_we_n, mem_rd_n, mem_psen_n, mem_sfr_n}, 4'hF);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_pulses",
            {cpu_data_rdy, cpu_err, dma_ack, dma_err, bus_owner}, 0);
        chk("reset_rdata", {cpu_rdata, dma_rdata}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        issue_cpu(3'b101, 1'b1, 16'h1234, 8'h00);
        serve(2, 8'hA5);
        issue_dma(1'b1, 16'h8000, 8'h3C);
        serve(3, 8'h77);
        issue_cpu(3'b110, 1'b1, 16'h0040, 8'h00);
        serve(0, 8'h00);
        issue_cpu(3'b101, 1'b0, 16'h0081, 8'h00);
        serve(TMO, 8'h5A);
        issue_cpu(3'b011, 1'b1, 16'h2000, 8'h99);
        serve(0, 8'h11);
        issue_cpu(3'b001, 1'b0, 16'h3000, 8'h42);
        serve(1, 8'hEE);

        for (int i = 0; i < 20; i++) rand_round(100, 100);
        for (int i = 0; i < 60; i++) rand_round(50, 50);
        while (cpu_pend || dma_pend) serve(pick_lat(), 8'($urandom));

        abort_test();
        issue_cpu(3'b101, 1'b1, 16'h0F0F, 8'h00);
        serve(1, 8'hC3);
        for (int i = 0; i < 30; i++) rand_round(70, 70);
        while (cpu_pend || dma_pend) serve(pick_lat(), 8'($urandom));

        repeat (4) @(negedge clk);
        chk("queues_drained", bus_q.size() + resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
